// File: rtl/div_seq.sv
// div_seq: iterative radix-2 restoring divider for DIV.W/DIV.WU/MOD.W/MOD.WU.
// One operation at a time. A fixed 33-cycle latency runs from accept to out_valid.
// The sequencer works on operand magnitudes and applies the signs at the end.
module div_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        is_unsigned,
    input  logic        use_mod,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] div_mag;
    logic [31:0] src1_raw;
    logic        q_neg;
    logic        r_neg;
    logic        div_zero;
    logic        mod_sel;
    logic [4:0]  count;

    logic        accept;
    logic [31:0] src1_mag;
    logic [31:0] src2_mag;
    logic [32:0] rem_shifted;
    logic [33:0] trial;
    logic [32:0] step_rem;
    logic [31:0] step_quo;
    logic [31:0] quotient_final;
    logic [31:0] remainder_final;
    logic [31:0] result_final;

    // State register; reset and flush both return the sequencer to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs, decoded purely from the registered state.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    accept     = 1'b1;
                    next_state = ITER;
                end
            end
            ITER: begin
                busy = 1'b1;
                if (count == 5'd31) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (flush) begin
            next_state = IDLE;
        end
    end

    // Operand magnitudes, one restoring step, and the sign/zero fix-up of the last step.
    always_comb begin
        src1_mag    = (!is_unsigned && src1[31]) ? (32'd0 - src1) : src1;
        src2_mag    = (!is_unsigned && src2[31]) ? (32'd0 - src2) : src2;
        rem_shifted = {rem[31:0], quo[31]};
        trial       = {1'b0, rem_shifted} - {2'b00, div_mag};
        if (trial[33]) begin
            step_rem = rem_shifted;
            step_quo = {quo[30:0], 1'b0};
        end else begin
            step_rem = trial[32:0];
            step_quo = {quo[30:0], 1'b1};
        end
        if (div_zero) begin
            quotient_final  = 32'hFFFF_FFFF;
            remainder_final = src1_raw;
        end else begin
            quotient_final  = q_neg ? (32'd0 - step_quo) : step_quo;
            remainder_final = r_neg ? (32'd0 - step_rem[31:0]) : step_rem[31:0];
        end
        result_final = mod_sel ? remainder_final : quotient_final;
    end

    // Datapath registers: latch operands on accept, iterate in ITER, hold the result in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem      <= '0;
            quo      <= '0;
            div_mag  <= '0;
            src1_raw <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div_zero <= 1'b0;
            mod_sel  <= 1'b0;
            count    <= '0;
            result   <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (accept) begin
            rem      <= '0;
            quo      <= src1_mag;
            div_mag  <= src2_mag;
            src1_raw <= src1;
            q_neg    <= !is_unsigned && (src1[31] ^ src2[31]);
            r_neg    <= !is_unsigned && src1[31];
            div_zero <= (src2 == 32'd0);
            mod_sel  <= use_mod;
            count    <= '0;
        end else if (state == ITER) begin
            rem   <= step_rem;
            quo   <= step_quo;
            count <= count + 5'd1;
            if (count == 5'd31) begin
                result <= result_final;
            end
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed vector table, random operations against an arithmetic
// reference, and hand-written handshake/flush/reset sequences for div_seq.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        is_unsigned;
    logic        use_mod;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        u;
        logic        m;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expected;
    } vec_t;

    vec_t vectors[14];

    div_seq dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .is_unsigned(is_unsigned),
        .use_mod    (use_mod),
        .src1       (src1),
        .src2       (src2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .busy       (busy)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Reference: plain integer division with the RISC-style divide-by-zero and overflow results.
    function automatic logic [31:0] refDiv(input logic u, input logic m,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        int          sa;
        int          sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (u) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
        end
        return m ? r : q;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation, accept it, then wait (bounded) for out_valid.
    // lat counts cycles from the accept edge to the first cycle with out_valid.
    task automatic applyStimulus(input logic u, input logic m, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] res,
                                 output int lat);
        checkOutput("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        is_unsigned = u;
        use_mod     = m;
        src1        = a;
        src2        = b;
        in_valid    = 1'b1;
        tick();
        in_valid    = 1'b0;
        is_unsigned = ~u;
        use_mod     = ~m;
        src1        = $urandom;
        src2        = $urandom;
        lat = 1;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
        res = result;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] held;
        logic [31:0] exp_val;
        int          lat;
        int          n;
        logic        seen;
        logic        u;
        logic        m;
        logic [31:0] a;
        logic [31:0] b;

        vectors[0]  = '{1'b1, 1'b0, 32'd100,       32'd7,         32'd14};
        vectors[1]  = '{1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE};
        vectors[2]  = '{1'b0, 1'b0, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2};
        vectors[3]  = '{1'b1, 1'b0, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF};
        vectors[4]  = '{1'b0, 1'b0, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF};
        vectors[5]  = '{1'b1, 1'b1, 32'h1234_5678, 32'd0,         32'h1234_5678};
        vectors[6]  = '{1'b0, 1'b1, 32'h1234_5678, 32'd0,         32'h1234_5678};
        vectors[7]  = '{1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vectors[8]  = '{1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
        vectors[9]  = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF};
        vectors[10] = '{1'b0, 1'b0, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD};
        vectors[11] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'd10,        32'd5};
        vectors[12] = '{1'b0, 1'b0, 32'h8000_0000, 32'd1,         32'h8000_0000};
        vectors[13] = '{1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};

        reset       = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        is_unsigned = 1'b0;
        use_mod     = 1'b0;
        src1        = '0;
        src2        = '0;
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset_in_ready",  {31'd0, in_ready},  32'd1);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_busy",      {31'd0, busy},      32'd0);
        checkOutput("reset_result",    result,             32'd0);

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vectors[i].u, vectors[i].m, vectors[i].a, vectors[i].b, res, lat);
            checkOutput($sformatf("vec%0d_result", i), res, vectors[i].expected);
            checkOutput($sformatf("vec%0d_latency", i), lat, 32'd33);
            consume();
        end

        for (int i = 0; i < 40; i++) begin
            u = 1'($urandom);
            m = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 20);
                3:       b = 32'd0 - $urandom_range(1, 20);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            applyStimulus(u, m, a, b, res, lat);
            checkOutput($sformatf("rand%0d_result", i), res, refDiv(u, m, a, b));
            if (lat != 33) checkOutput($sformatf("rand%0d_latency", i), lat, 32'd33);
            consume();
        end

        // Backpressure: out_ready low for 10 cycles after out_valid.
        applyStimulus(1'b1, 1'b0, 32'd1000, 32'd3, res, lat);
        checkOutput("bp_result", res, 32'd333);
        held = result;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("bp_hold%0d", i), result, held);
            checkOutput($sformatf("bp_in_ready%0d", i), {31'd0, in_ready}, 32'd0);
            checkOutput($sformatf("bp_out_valid%0d", i), {31'd0, out_valid}, 32'd1);
        end
        consume();
        checkOutput("bp_release_in_ready",  {31'd0, in_ready},  32'd1);
        checkOutput("bp_release_out_valid", {31'd0, out_valid}, 32'd0);

        // Flush at T+15 in the middle of ITER.
        is_unsigned = 1'b1;
        use_mod     = 1'b0;
        src1        = 32'd500;
        src2        = 32'd5;
        in_valid    = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        checkOutput("flush_busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("flush_busy",     {31'd0, busy},     32'd0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        checkOutput("flush_no_out_valid", {31'd0, seen}, 32'd0);

        // Flush together with in_valid in IDLE: not accepted.
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        checkOutput("flush_idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("flush_idle_in_ready", {31'd0, in_ready}, 32'd1);

        applyStimulus(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, res, lat);
        checkOutput("after_flush_result",  res, 32'hFFFF_FFFE);
        checkOutput("after_flush_latency", lat, 32'd33);
        consume();

        // Reset in the middle of ITER, then a fresh operation.
        in_valid = 1'b1;
        src1     = 32'd77;
        src2     = 32'd7;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midreset_busy",   {31'd0, busy}, 32'd0);
        checkOutput("midreset_result", result,        32'd0);
        applyStimulus(1'b1, 1'b1, 32'd77, 32'd10, res, lat);
        checkOutput("after_reset_result",  res, 32'd7);
        checkOutput("after_reset_latency", lat, 32'd33);
        consume();

        // Back-to-back with out_ready tied high and in_valid held high.
        out_ready   = 1'b1;
        is_unsigned = 1'b1;
        use_mod     = 1'b0;
        src1        = 32'hFFFF_FFFF;
        src2        = 32'd1;
        in_valid    = 1'b1;
        tick();
        is_unsigned = 1'b0;
        use_mod     = 1'b0;
        src1        = 32'd7;
        src2        = 32'hFFFF_FFFE;
        n     = 0;
        seen  = 1'b0;
        held  = '0;
        while (!in_ready && n < 60) begin
            if (out_valid) begin
                seen = 1'b1;
                held = result;
            end
            tick();
            n++;
        end
        checkOutput("b2b_first_seen",   {31'd0, seen}, 32'd1);
        checkOutput("b2b_first_result", held, 32'hFFFF_FFFF);
        tick();
        n++;
        checkOutput("b2b_accept_spacing", n, 32'd34);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
        exp_val = refDiv(1'b0, 1'b0, 32'd7, 32'hFFFF_FFFE);
        checkOutput("b2b_second_result",  result, exp_val);
        checkOutput("b2b_second_latency", lat, 32'd33);
        tick();
        out_ready = 1'b0;
        checkOutput("b2b_end_in_ready", {31'd0, in_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle iterative 32-bit integer divider controller for the EX stage. It replaces the single-cycle combinational divide/modulo path with a radix-2 restoring division sequencer. Issue logic hands it one operation at a time through a valid/ready handshake, and the writeback mux collects the result through a second valid/ready handshake. It covers DIV.W, DIV.WU, MOD.W and MOD.WU. It accepts a pipeline flush that cancels any operation in flight.

## Interface
- No parameters; the operand width is fixed at 32.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous cancel of any operation in flight; takes priority over every other input.
- in_valid  in  1  an operation is presented on is_unsigned/use_mod/src1/src2.
- in_ready  out  1  the block can accept an operation; high only in IDLE.
- is_unsigned  in  1  1 = unsigned divide, 0 = two's-complement signed divide.
- use_mod  in  1  1 = return the remainder, 0 = return the quotient.
- src1  in  32  dividend.
- src2  in  32  divisor.
- out_valid  out  1  result is valid; high only in DONE.
- out_ready  in  1  the consumer takes the result.
- result  out  32  quotient or remainder; held stable while out_valid=1.
- busy  out  1  high in ITER or DONE.

## Operation
- States: IDLE, ITER, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid (and no flush), latch:
    - is_unsigned, use_mod;
    - the divisor-zero flag (src2==0);
    - the raw src1;
    - quotient sign q_neg = ~is_unsigned & (src1[31]^src2[31]);
    - remainder sign r_neg = ~is_unsigned & src1[31];
    - magnitudes |src1| and |src2| (negated only when signed and bit31 set; |0x80000000| = 0x80000000 as unsigned).
  - Clear the 33-bit partial remainder, load the quotient shift register with |src1|, set the 5-bit step counter to 0, and go to ITER.
- **ITER**, one step per cycle for 32 cycles:
  - Shift {rem, quo} left by 1.
  - Compute trial = rem_shifted - {1'b0, |src2|}.
  - If trial is non-negative: rem = trial and quo[0]=1. Otherwise keep rem and set quo[0]=0.
  - The counter increments each step. On the step with counter==31, compute the final result into the result register and go to DONE.
- **Final result rule** (first matching case wins):
  - Divisor zero: quotient = 0xFFFF_FFFF and remainder = raw src1, for both signednesses.
  - Otherwise: quotient = q_neg ? -quo : quo, and remainder = r_neg ? -rem[31:0] : rem[31:0].
  - result = use_mod ? remainder : quotient.
- **Signed overflow** (0x8000_0000 / 0xFFFF_FFFF) falls out naturally: quotient 0x8000_0000, remainder 0. No special-case logic.
- **DONE**
  - out_valid=1 and result is held.
  - When out_ready=1, return to IDLE next cycle. There is no same-cycle accept of a new operation.
- **flush=1**, any state: next state IDLE, out_valid drops next cycle, and a result in DONE is discarded.
  - flush together with in_valid in IDLE: the operation is not accepted.
- **reset**: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, counter=0, all operand registers 0.

## Timing
- Accept at cycle T when in_valid & in_ready.
- ITER spans cycles T+1..T+32.
- out_valid=1 first at T+33.
- Fixed latency of 33 cycles, independent of operand values, divisor zero and signedness.
- Consumer handshake at cycle D (out_valid & out_ready): IDLE and in_ready=1 at D+1.
  - Minimum initiation interval is 34 cycles with out_ready tied high.
- out_valid, in_ready and busy are decoded from registered state only.
  - No combinational path from in_valid or out_ready to any output.
- Operand inputs are sampled only in the accept cycle. Changes during ITER/DONE have no effect.
- If out_ready is held low, DONE persists indefinitely with result stable.
- Reset or flush mid-ITER: IDLE on the next edge, and the counter restarts at 0 on the next accept.

## Test plan
- Unsigned quotient: src1=100, src2=7, is_unsigned=1, use_mod=0 -> result=14, out_valid exactly 33 cycles after accept.
- Signed remainder: src1=0xFFFF_FF9C (-100), src2=7, is_unsigned=0, use_mod=1 -> result=0xFFFF_FFFE (-2). Same operands with use_mod=0 -> 0xFFFF_FFF2 (-14).
- Divide by zero, unsigned/quotient and signed/mod cases:
  - src1=0x1234_5678, src2=0, use_mod=0 -> 0xFFFF_FFFF, for both signednesses.
  - Same src1 and src2 with use_mod=1 -> 0x1234_5678.
- Signed overflow: src1=0x8000_0000, src2=0xFFFF_FFFF, signed -> quotient 0x8000_0000, remainder 0.
- Backpressure and flush, run as two separate checks:
  - Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result stable and in_ready=0 throughout; raising out_ready gives in_ready=1 the next cycle.
  - Flush: assert flush at T+15 mid-ITER -> IDLE at T+16 and no out_valid.
- Back-to-back with out_ready=1: 0xFFFF_FFFF/1 unsigned then 7/0xFFFF_FFFE signed (quotient) -> results 0xFFFF_FFFF then 0xFFFF_FFFD, accepts 34 cycles apart.
